// File: rtl/y86_branch_predictor.sv
// y86_branch_predictor: next-PC predictor for the Y86-64 fetch stage.
// Direct-mapped, tagged table of saturating counters for conditional jumps,
// trained from execute, plus hit/miss statistics.
// Optional return-address stack for `ret` targets, enabled by defining BP_RAS_EN.
module y86_branch_predictor #(
  parameter int unsigned ENTRIES   = 16,
  parameter int unsigned CTR_BITS  = 2,
  parameter int unsigned RAS_DEPTH = 8,
  parameter int unsigned PC_W      = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            f_valid,
  input  logic [PC_W-1:0] f_pc,
  input  logic [3:0]      f_icode,
  input  logic [3:0]      f_ifun,
  input  logic [PC_W-1:0] f_valC,
  input  logic [PC_W-1:0] f_valP,
  output logic [PC_W-1:0] f_predPC,
  output logic            f_pred_taken,
  input  logic            e_upd,
  input  logic [PC_W-1:0] e_pc,
  input  logic            e_cnd,
  input  logic            e_pred_taken,
  output logic [31:0]     hit_cnt,
  output logic [31:0]     miss_cnt,
  output logic [3:0]      ras_count
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = PC_W - IDX_W;

  localparam logic [3:0] IJXX  = 4'h7;
  localparam logic [3:0] ICALL = 4'h8;
  localparam logic [3:0] IRET  = 4'h9;

  localparam logic [CTR_BITS-1:0] CTR_MAX    = '1;
  localparam logic [CTR_BITS-1:0] CTR_WEAK_T = CTR_BITS'(1) << (CTR_BITS - 1);
  localparam logic [CTR_BITS-1:0] CTR_WEAK_N = CTR_WEAK_T - CTR_BITS'(1);

  logic [ENTRIES-1:0]  r_valid;
  logic [TAG_W-1:0]    r_tag [ENTRIES];
  logic [CTR_BITS-1:0] r_ctr [ENTRIES];

  logic [IDX_W-1:0]    w_f_idx;
  logic [TAG_W-1:0]    w_f_tag;
  logic                w_f_hit;
  logic                w_lkp_taken;
  logic [IDX_W-1:0]    w_e_idx;
  logic [TAG_W-1:0]    w_e_tag;
  logic                w_e_hit;
  logic [CTR_BITS-1:0] w_e_ctr;
  logic [PC_W-1:0]     w_ras_top;
  logic                w_ras_nonempty;

  // Fetch-side lookup; a miss falls back to always-taken
  assign w_f_idx     = f_pc[IDX_W-1:0];
  assign w_f_tag     = f_pc[PC_W-1:IDX_W];
  assign w_f_hit     = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
  assign w_lkp_taken = w_f_hit ? r_ctr[w_f_idx][CTR_BITS-1] : 1'b1;

  // Execute-side resolution lookup
  assign w_e_idx = e_pc[IDX_W-1:0];
  assign w_e_tag = e_pc[PC_W-1:IDX_W];
  assign w_e_hit = r_valid[w_e_idx] && (r_tag[w_e_idx] == w_e_tag);
  assign w_e_ctr = r_ctr[w_e_idx];

  // Next-PC selection by instruction class
  always_comb begin
    f_predPC     = f_valP;
    f_pred_taken = 1'b0;
    case (f_icode)
      IJXX: begin
        if (f_ifun == 4'h0) begin
          f_predPC = f_valC;
        end else begin
          f_pred_taken = w_lkp_taken;
          f_predPC     = w_lkp_taken ? f_valC : f_valP;
        end
      end
      ICALL: f_predPC = f_valC;
      IRET: begin
        if (w_ras_nonempty) f_predPC = w_ras_top;
      end
      default: ;
    endcase
  end

  // Table training: saturating update on a tag hit, allocate otherwise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_tag[i] <= '0;
        r_ctr[i] <= '0;
      end
    end else if (e_upd) begin
      if (w_e_hit) begin
        if (e_cnd) begin
          if (w_e_ctr != CTR_MAX) r_ctr[w_e_idx] <= w_e_ctr + CTR_BITS'(1);
        end else begin
          if (w_e_ctr != '0) r_ctr[w_e_idx] <= w_e_ctr - CTR_BITS'(1);
        end
      end else begin
        r_valid[w_e_idx] <= 1'b1;
        r_tag[w_e_idx]   <= w_e_tag;
        r_ctr[w_e_idx]   <= e_cnd ? CTR_WEAK_T : CTR_WEAK_N;
      end
    end
  end

  // Resolved-prediction statistics, wrapping at 2^32
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (e_upd) begin
      if (e_pred_taken == e_cnd) hit_cnt <= hit_cnt + 32'd1;
      else                       miss_cnt <= miss_cnt + 32'd1;
    end
  end

`ifdef BP_RAS_EN
  localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

  logic [PC_W-1:0]  r_ras [RAS_DEPTH];
  logic [PTR_W-1:0] r_ras_ptr;
  logic [CNT_W-1:0] r_ras_cnt;
  logic [PTR_W-1:0] w_ptr_inc;
  logic [PTR_W-1:0] w_ptr_dec;

  // r_ras_ptr is the next free slot; the top of stack sits just below it
  assign w_ptr_inc      = (r_ras_ptr == PTR_W'(RAS_DEPTH - 1)) ? '0 : r_ras_ptr + PTR_W'(1);
  assign w_ptr_dec      = (r_ras_ptr == '0) ? PTR_W'(RAS_DEPTH - 1) : r_ras_ptr - PTR_W'(1);
  assign w_ras_top      = r_ras[w_ptr_dec];
  assign w_ras_nonempty = (r_ras_cnt != '0);
  assign ras_count      = 4'(r_ras_cnt);

  // Circular return stack: push on call (overwriting oldest when full), pop on ret
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ras_ptr <= '0;
      r_ras_cnt <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) r_ras[i] <= '0;
    end else if (f_valid) begin
      if (f_icode == ICALL) begin
        r_ras[r_ras_ptr] <= f_valP;
        r_ras_ptr        <= w_ptr_inc;
        if (r_ras_cnt != CNT_W'(RAS_DEPTH)) r_ras_cnt <= r_ras_cnt + CNT_W'(1);
      end else if ((f_icode == IRET) && w_ras_nonempty) begin
        r_ras_ptr <= w_ptr_dec;
        r_ras_cnt <= r_ras_cnt - CNT_W'(1);
      end
    end
  end
`else
  logic w_unused;

  // No return stack: ret falls through to f_valP
  assign w_ras_top      = '0;
  assign w_ras_nonempty = 1'b0;
  assign ras_count      = 4'd0;
  assign w_unused       = ^{f_valid, 32'(RAS_DEPTH)};
`endif

endmodule

// File: tb/tb_y86_branch_predictor.sv
// Directed self-checking bench for y86_branch_predictor (RAS_DEPTH=2).
module tb_y86_branch_predictor;

  logic        clk;
  logic        reset;
  logic        f_valid;
  logic [63:0] f_pc;
  logic [3:0]  f_icode;
  logic [3:0]  f_ifun;
  logic [63:0] f_valC;
  logic [63:0] f_valP;
  logic [63:0] f_predPC;
  logic        f_pred_taken;
  logic        e_upd;
  logic [63:0] e_pc;
  logic        e_cnd;
  logic        e_pred_taken;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
  logic [3:0]  ras_count;

  int errors = 0;
  int checks = 0;
  int exp_hit = 0;
  int exp_miss = 0;

  y86_branch_predictor #(
    .ENTRIES(16), .CTR_BITS(2), .RAS_DEPTH(2), .PC_W(64)
  ) dut (
    .clk(clk), .reset(reset), .f_valid(f_valid), .f_pc(f_pc),
    .f_icode(f_icode), .f_ifun(f_ifun), .f_valC(f_valC), .f_valP(f_valP),
    .f_predPC(f_predPC), .f_pred_taken(f_pred_taken),
    .e_upd(e_upd), .e_pc(e_pc), .e_cnd(e_cnd), .e_pred_taken(e_pred_taken),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .ras_count(ras_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive fetch inputs and let combinational outputs settle
  task automatic fetch(input logic [63:0] pc, input logic [3:0] ic, input logic [3:0] fn,
                       input logic [63:0] vc, input logic [63:0] vp);
    f_pc = pc; f_icode = ic; f_ifun = fn; f_valC = vc; f_valP = vp;
    #1;
  endtask

  // One resolved jump update across one clock edge; tracks expected statistics
  task automatic upd(input logic [63:0] pc, input logic cnd, input logic pt);
    e_upd = 1'b1; e_pc = pc; e_cnd = cnd; e_pred_taken = pt;
    @(posedge clk); #1;
    e_upd = 1'b0;
    if (pt == cnd) exp_hit++; else exp_miss++;
  endtask

  task automatic test_reset;
    reset = 1'b1; f_valid = 1'b0; e_upd = 1'b0; e_pc = '0; e_cnd = 1'b0; e_pred_taken = 1'b0;
    fetch(64'h20, 4'h7, 4'h1, 64'h100, 64'h29);
    checks++; if (f_pred_taken !== 1'b1) begin errors++; $display("FAIL in_reset_taken: got %b want 1", f_pred_taken); end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    checks++; if (f_pred_taken !== 1'b1) begin errors++; $display("FAIL reset_taken: got %b want 1", f_pred_taken); end
    checks++; if (f_predPC !== 64'h100) begin errors++; $display("FAIL reset_predpc: got %h want 100", f_predPC); end
    checks++; if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin errors++; $display("FAIL reset_stats: got %0d/%0d want 0/0", hit_cnt, miss_cnt); end
    checks++; if (ras_count !== 4'd0) begin errors++; $display("FAIL reset_ras: got %0d want 0", ras_count); end
  endtask

  task automatic test_icodes;
    fetch(64'h20, 4'h7, 4'h0, 64'h140, 64'h29);
    checks++; if (f_predPC !== 64'h140 || f_pred_taken !== 1'b0) begin errors++; $display("FAIL jmp_uncond: got %h/%b want 140/0", f_predPC, f_pred_taken); end
    fetch(64'h20, 4'h8, 4'h0, 64'h180, 64'h29);
    checks++; if (f_predPC !== 64'h180 || f_pred_taken !== 1'b0) begin errors++; $display("FAIL call: got %h/%b want 180/0", f_predPC, f_pred_taken); end
    fetch(64'h20, 4'h3, 4'h0, 64'h1c0, 64'h2a);
    checks++; if (f_predPC !== 64'h2a || f_pred_taken !== 1'b0) begin errors++; $display("FAIL irmovq: got %h/%b want 2a/0", f_predPC, f_pred_taken); end
    fetch(64'h20, 4'h9, 4'h0, 64'h1c0, 64'h21);
    checks++; if (f_predPC !== 64'h21) begin errors++; $display("FAIL ret_empty: got %h want 21", f_predPC); end
  endtask

  task automatic test_not_taken_train;
    fetch(64'h20, 4'h7, 4'h1, 64'h100, 64'h29);
    upd(64'h20, 1'b0, 1'b1);
    checks++; if (f_pred_taken !== 1'b0) begin errors++; $display("FAIL alloc_nt: got %b want 0", f_pred_taken); end
    upd(64'h20, 1'b0, 1'b1);
    checks++; if (f_predPC !== 64'h29) begin errors++; $display("FAIL nt_predpc: got %h want 29", f_predPC); end
    checks++; if (miss_cnt !== 32'd2 || hit_cnt !== 32'd0) begin errors++; $display("FAIL nt_stats: got %0d/%0d want 0/2", hit_cnt, miss_cnt); end
  endtask

  task automatic test_taken_saturate;
    upd(64'h20, 1'b1, 1'b1);
    checks++; if (f_pred_taken !== 1'b0) begin errors++; $display("FAIL ctr01: got %b want 0", f_pred_taken); end
    upd(64'h20, 1'b1, 1'b1);
    checks++; if (f_pred_taken !== 1'b1 || f_predPC !== 64'h100) begin errors++; $display("FAIL ctr10: got %b/%h want 1/100", f_pred_taken, f_predPC); end
    upd(64'h20, 1'b1, 1'b1);
    upd(64'h20, 1'b1, 1'b1);
    upd(64'h20, 1'b0, 1'b1);
    checks++; if (f_pred_taken !== 1'b1) begin errors++; $display("FAIL sat_hold: got %b want 1", f_pred_taken); end
    checks++; if (hit_cnt !== 32'd4 || miss_cnt !== 32'd3) begin errors++; $display("FAIL sat_stats: got %0d/%0d want 4/3", hit_cnt, miss_cnt); end
    upd(64'h20, 1'b0, 1'b1);
    checks++; if (f_pred_taken !== 1'b0) begin errors++; $display("FAIL sat_dec: got %b want 0", f_pred_taken); end
  endtask

  task automatic test_alias;
    fetch(64'h30, 4'h7, 4'h2, 64'h200, 64'h39);
    checks++; if (f_pred_taken !== 1'b1 || f_predPC !== 64'h200) begin errors++; $display("FAIL alias_miss: got %b/%h want 1/200", f_pred_taken, f_predPC); end
    upd(64'h30, 1'b0, 1'b1);
    checks++; if (f_pred_taken !== 1'b0 || f_predPC !== 64'h39) begin errors++; $display("FAIL alias_alloc: got %b/%h want 0/39", f_pred_taken, f_predPC); end
    fetch(64'h20, 4'h7, 4'h1, 64'h100, 64'h29);
    checks++; if (f_pred_taken !== 1'b1) begin errors++; $display("FAIL alias_evict: got %b want 1", f_pred_taken); end
  endtask

  task automatic test_same_cycle;
    upd(64'h20, 1'b0, 1'b0);
    checks++; if (f_pred_taken !== 1'b0) begin errors++; $display("FAIL sc_setup: got %b want 0", f_pred_taken); end
    e_upd = 1'b1; e_pc = 64'h20; e_cnd = 1'b1; e_pred_taken = 1'b0;
    @(negedge clk);
    checks++; if (f_pred_taken !== 1'b0 || f_predPC !== 64'h29) begin errors++; $display("FAIL sc_old: got %b/%h want 0/29", f_pred_taken, f_predPC); end
    @(posedge clk); #1;
    e_upd = 1'b0;
    exp_miss++;
    checks++; if (f_pred_taken !== 1'b1 || f_predPC !== 64'h100) begin errors++; $display("FAIL sc_new: got %b/%h want 1/100", f_pred_taken, f_predPC); end
    checks++; if (hit_cnt !== 32'(exp_hit) || miss_cnt !== 32'(exp_miss)) begin errors++; $display("FAIL stats_total: got %0d/%0d want %0d/%0d", hit_cnt, miss_cnt, exp_hit, exp_miss); end
  endtask

  task automatic test_ras;
    fetch(64'h40, 4'h8, 4'h0, 64'h300, 64'h10);
    f_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (ras_count !== 4'd0) begin errors++; $display("FAIL ras_novalid: got %0d want 0", ras_count); end
    f_valid = 1'b1;
    fetch(64'h40, 4'h8, 4'h0, 64'h300, 64'h10); @(posedge clk); #1;
    fetch(64'h50, 4'h8, 4'h0, 64'h300, 64'h20); @(posedge clk); #1;
    fetch(64'h60, 4'h8, 4'h0, 64'h300, 64'h30); @(posedge clk); #1;
`ifdef BP_RAS_EN
    checks++; if (ras_count !== 4'd2) begin errors++; $display("FAIL ras_full: got %0d want 2", ras_count); end
    fetch(64'h70, 4'h9, 4'h0, 64'h0, 64'h99);
    checks++; if (f_predPC !== 64'h30) begin errors++; $display("FAIL ras_pop1: got %h want 30", f_predPC); end
    @(posedge clk); #1;
    checks++; if (f_predPC !== 64'h20 || ras_count !== 4'd1) begin errors++; $display("FAIL ras_pop2: got %h/%0d want 20/1", f_predPC, ras_count); end
    @(posedge clk); #1;
    checks++; if (f_predPC !== 64'h99 || ras_count !== 4'd0) begin errors++; $display("FAIL ras_pop3: got %h/%0d want 99/0", f_predPC, ras_count); end
    @(posedge clk); #1;
    checks++; if (ras_count !== 4'd0) begin errors++; $display("FAIL ras_underflow: got %0d want 0", ras_count); end
    fetch(64'h80, 4'h8, 4'h0, 64'h300, 64'h88); @(posedge clk); #1;
    checks++; if (ras_count !== 4'd1) begin errors++; $display("FAIL ras_repush: got %0d want 1", ras_count); end
`else
    checks++; if (ras_count !== 4'd0) begin errors++; $display("FAIL ras_off_count: got %0d want 0", ras_count); end
    fetch(64'h70, 4'h9, 4'h0, 64'h0, 64'h99);
    checks++; if (f_predPC !== 64'h99) begin errors++; $display("FAIL ras_off_ret: got %h want 99", f_predPC); end
`endif
    f_valid = 1'b0;
  endtask

  task automatic test_reset_midrun;
    fetch(64'h28, 4'h7, 4'h3, 64'h400, 64'h31);
    upd(64'h28, 1'b0, 1'b0);
    checks++; if (f_pred_taken !== 1'b0) begin errors++; $display("FAIL mid_pre: got %b want 0", f_pred_taken); end
    #2 reset = 1'b1;
    #1;
    checks++; if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin errors++; $display("FAIL mid_stats: got %0d/%0d want 0/0", hit_cnt, miss_cnt); end
    checks++; if (ras_count !== 4'd0) begin errors++; $display("FAIL mid_ras: got %0d want 0", ras_count); end
    checks++; if (f_pred_taken !== 1'b1 || f_predPC !== 64'h400) begin errors++; $display("FAIL mid_valid: got %b/%h want 1/400", f_pred_taken, f_predPC); end
    e_upd = 1'b1; e_pc = 64'h50; e_cnd = 1'b0; e_pred_taken = 1'b0;
    @(posedge clk); #1;
    e_upd = 1'b0;
    reset = 1'b0;
    fetch(64'h50, 4'h7, 4'h1, 64'h500, 64'h59);
    checks++; if (f_pred_taken !== 1'b1 || f_predPC !== 64'h500) begin errors++; $display("FAIL rst_upd_ignored: got %b/%h want 1/500", f_pred_taken, f_predPC); end
    checks++; if (hit_cnt !== 32'd0) begin errors++; $display("FAIL rst_upd_stats: got %0d want 0", hit_cnt); end
  endtask

  initial begin
    test_reset;
    test_icodes;
    test_not_taken_train;
    test_taken_saturate;
    test_alias;
    test_same_cycle;
    test_ras;
    test_reset_midrun;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
